// File: rtl/bank_sc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bank_sc_arbiter
// Purpose  : Round-robin arbiter (xbar / refill / evict) feeding one
//            registered command slot toward the bank SRAM controller.
//            Optional starvation guard: define BANK_SC_ARB_AGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bank_sc_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_valid_i,
  output logic [NREQ-1:0] req_ready_o,
  input  logic [22:0]     req0_cmd_i,
  input  logic [22:0]     req1_cmd_i,
  input  logic [22:0]     req2_cmd_i,
  output logic            isu_sc_valid_o,
  input  logic            isu_sc_ready_i,
  output logic [1:0]      isu_sc_channel_id_o,
  output logic [2:0]      isu_sc_opcode_o,
  output logic [6:0]      isu_sc_set_way_offset_o,
  output logic [7:0]      isu_sc_wbuffer_id_o,
  output logic [2:0]      isu_sc_xbar_rob_num_o,
  output logic [1:0]      arb_grant_id_o
);

  localparam logic [2:0] c_AGE_MAX = 3'd7;

  logic        r_out_valid;
  logic [1:0]  r_rr_ptr;
  logic [22:0] r_cmd;
  logic [1:0]  r_grant_id;

  logic        w_pop;
  logic        w_slot_free;
  logic        w_grant;
  logic [1:0]  w_rr_eff;
  logic [1:0]  w_rr_winner;
  logic [1:0]  w_winner;
  logic [22:0] w_sel_cmd;

  function automatic logic [1:0] mod3_add(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  assign w_pop       = r_out_valid & isu_sc_ready_i;
  assign w_slot_free = ~r_out_valid | w_pop;
  assign w_grant     = (|req_valid_i) & w_slot_free & ~rst_i;
  assign w_rr_eff    = (r_rr_ptr == 2'd3) ? 2'd0 : r_rr_ptr;

  // Walk the search order backwards so the earliest valid position wins.
  always_comb begin
    logic [1:0] idx;
    w_rr_winner = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      idx = mod3_add(w_rr_eff, 2'(k));
      if (req_valid_i[idx]) w_rr_winner = idx;
    end
  end

`ifdef BANK_SC_ARB_AGE_EN
  logic [2:0]      r_age [NREQ];
  logic [NREQ-1:0] w_sat;

  always_comb begin
    w_winner = w_rr_winner;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_sat[i] = req_valid_i[i] & (r_age[i] == c_AGE_MAX);
      if (w_sat[i]) w_winner = 2'(i);
    end
  end

  // Age tracks consecutive cycles a requester sat valid without a grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREQ; i++) r_age[i] <= 3'd0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid_i[i] || (w_grant && (w_winner == 2'(i))))
          r_age[i] <= 3'd0;
        else if (r_age[i] != c_AGE_MAX)
          r_age[i] <= r_age[i] + 3'd1;
      end
    end
  end
`else
  assign w_winner = w_rr_winner;
`endif

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      req_ready_o[i] = w_grant && (w_winner == 2'(i));
  end

  always_comb begin
    case (w_winner)
      2'd1:    w_sel_cmd = req1_cmd_i;
      2'd2:    w_sel_cmd = req2_cmd_i;
      default: w_sel_cmd = req0_cmd_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_rr_ptr    <= 2'd0;
      r_cmd       <= 23'd0;
      r_grant_id  <= 2'd0;
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_cmd       <= w_sel_cmd;
      r_grant_id  <= w_winner;
      r_rr_ptr    <= (w_winner == 2'd2) ? 2'd0 : w_winner + 2'd1;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  assign isu_sc_valid_o          = r_out_valid;
  assign isu_sc_channel_id_o     = r_cmd[22:21];
  assign isu_sc_opcode_o         = r_cmd[20:18];
  assign isu_sc_set_way_offset_o = r_cmd[17:11];
  assign isu_sc_wbuffer_id_o     = r_cmd[10:3];
  assign isu_sc_xbar_rob_num_o   = r_cmd[2:0];
  assign arb_grant_id_o          = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_bank_sc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_sc_arbiter
// Purpose  : Directed self-checking bench for bank_sc_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_sc_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [22:0] cmd0, cmd1, cmd2;
  logic        sc_valid;
  logic        sc_ready;
  logic [1:0]  ch;
  logic [2:0]  op;
  logic [6:0]  swo;
  logic [7:0]  wb;
  logic [2:0]  rob;
  logic [1:0]  gid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bank_sc_arbiter #(.NREQ(3)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .req_valid_i             (req_valid),
    .req_ready_o             (req_ready),
    .req0_cmd_i              (cmd0),
    .req1_cmd_i              (cmd1),
    .req2_cmd_i              (cmd2),
    .isu_sc_valid_o          (sc_valid),
    .isu_sc_ready_i          (sc_ready),
    .isu_sc_channel_id_o     (ch),
    .isu_sc_opcode_o         (op),
    .isu_sc_set_way_offset_o (swo),
    .isu_sc_wbuffer_id_o     (wb),
    .isu_sc_xbar_rob_num_o   (rob),
    .arb_grant_id_o          (gid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 3'b000; sc_ready = 1'b0;
    cmd0 = 23'd0; cmd1 = 23'd0; cmd2 = 23'd0;
    cyc(); cyc();
    req_valid = 3'b111; #1;
    chk("ready_in_reset", 32'(req_ready), 32'h0);
    cyc();

    // reset state
    rst = 1'b0; req_valid = 3'b000; #1;
    chk("rst_valid", 32'(sc_valid), 32'h0);
    chk("rst_gid", 32'(gid), 32'h0);
    chk("rst_fields", 32'({ch, op, swo, wb, rob}), 32'h0);
    chk("rst_rr", 32'(dut.r_rr_ptr), 32'h0);

    // all three valid, sink always ready: grants 0,1,2,0
    cmd0 = 23'h000111; cmd1 = 23'h222222; cmd2 = 23'h333333;
    req_valid = 3'b111; sc_ready = 1'b1; #1;
    chk("rr_ready_c1", 32'(req_ready), 32'h1);
    chk("rr_valid_c1", 32'(sc_valid), 32'h0);
    cyc();
    chk("rr_ready_c2", 32'(req_ready), 32'h2);
    chk("rr_valid_c2", 32'(sc_valid), 32'h1);
    chk("rr_gid_c2", 32'(gid), 32'h0);
    chk("rr_cmd_c2", 32'({ch, op, swo, wb, rob}), 32'h000111);
    cyc();
    chk("rr_ready_c3", 32'(req_ready), 32'h4);
    chk("rr_gid_c3", 32'(gid), 32'h1);
    chk("rr_cmd_c3", 32'({ch, op, swo, wb, rob}), 32'h222222);
    cyc();
    chk("rr_ready_c4", 32'(req_ready), 32'h1);
    chk("rr_gid_c4", 32'(gid), 32'h2);
    chk("rr_cmd_c4", 32'({ch, op, swo, wb, rob}), 32'h333333);
    cyc();
    req_valid = 3'b000; #1;
    chk("rr_gid_c5", 32'(gid), 32'h0);
    chk("rr_valid_c5", 32'(sc_valid), 32'h1);
    chk("idle_ready", 32'(req_ready), 32'h0);
    chk("rr_ptr_c5", 32'(dut.r_rr_ptr), 32'h1);
    cyc();
    chk("drain_valid", 32'(sc_valid), 32'h0);

    // requester 1 alone, sink stalled: fields held
    cmd1 = 23'h1A5A5A; req_valid = 3'b010; sc_ready = 1'b0; #1;
    chk("stall_ready_first", 32'(req_ready), 32'h2);
    cyc();
    for (int k = 0; k < 3; k++) begin
      cmd1 = 23'h7FFFFF - 23'(k);
      #1;
      chk("stall_ready", 32'(req_ready), 32'h0);
      chk("stall_valid", 32'(sc_valid), 32'h1);
      chk("stall_gid", 32'(gid), 32'h1);
      chk("stall_ch", 32'(ch), 32'h0);
      chk("stall_op", 32'(op), 32'h6);
      chk("stall_swo", 32'(swo), 32'h4B);
      chk("stall_wb", 32'(wb), 32'h4B);
      chk("stall_rob", 32'(rob), 32'h2);
      cyc();
    end
    req_valid = 3'b000; sc_ready = 1'b1; #1;
    chk("stall_rr", 32'(dut.r_rr_ptr), 32'h2);
    cyc();

    // rr_ptr=2 with requesters 0 and 2: grant 2 then 0, pointer wraps
    cmd0 = 23'h0000AA; cmd2 = 23'h7FFFFF;
    req_valid = 3'b101; #1;
    chk("wrap_ready_2", 32'(req_ready), 32'h4);
    cyc();
    chk("wrap_rr_0", 32'(dut.r_rr_ptr), 32'h0);
    chk("wrap_gid_2", 32'(gid), 32'h2);
    chk("wrap_cmd_2", 32'({ch, op, swo, wb, rob}), 32'h7FFFFF);
    chk("wrap_ready_0", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 3'b000; #1;
    chk("wrap_rr_1", 32'(dut.r_rr_ptr), 32'h1);
    chk("wrap_gid_0", 32'(gid), 32'h0);
    chk("wrap_cmd_0", 32'({ch, op, swo, wb, rob}), 32'h0000AA);
    cyc();

    // withdrawn request while slot full: nothing changes
    cmd1 = 23'h155555; req_valid = 3'b010; sc_ready = 1'b0; #1;
    chk("full_load_ready", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 3'b001; #1;
    chk("full_ready_a", 32'(req_ready), 32'h0);
    cyc();
    chk("full_ready_b", 32'(req_ready), 32'h0);
    cyc();
    req_valid = 3'b000; #1;
    chk("drop_rr", 32'(dut.r_rr_ptr), 32'h2);
    chk("drop_gid", 32'(gid), 32'h1);
    chk("drop_cmd", 32'({ch, op, swo, wb, rob}), 32'h155555);
    chk("drop_valid", 32'(sc_valid), 32'h1);
    cyc();
    chk("drop_rr_later", 32'(dut.r_rr_ptr), 32'h2);
    chk("drop_cmd_later", 32'({ch, op, swo, wb, rob}), 32'h155555);

    // reset during a would-be handshake with the slot occupied
    cmd0 = 23'h0ABCDE; req_valid = 3'b001; sc_ready = 1'b1; rst = 1'b1; #1;
    chk("midrst_ready", 32'(req_ready), 32'h0);
    cyc();
    rst = 1'b0; req_valid = 3'b000; #1;
    chk("midrst_valid", 32'(sc_valid), 32'h0);
    chk("midrst_rr", 32'(dut.r_rr_ptr), 32'h0);
    chk("midrst_gid", 32'(gid), 32'h0);
    chk("midrst_fields", 32'({ch, op, swo, wb, rob}), 32'h0);

    // starvation: requester 2 waits while slot stalls; requester 1 briefly drops
    cmd0 = 23'h000001; cmd1 = 23'h000002; cmd2 = 23'h000003;
    req_valid = 3'b111; sc_ready = 1'b1; #1;
    chk("age_first_ready", 32'(req_ready), 32'h1);
    cyc();
    sc_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("age_wait_ready", 32'(req_ready), 32'h0);
      cyc();
    end
    req_valid = 3'b101; #1;
    chk("age_drop1_ready", 32'(req_ready), 32'h0);
    cyc();
    req_valid = 3'b111; sc_ready = 1'b1; #1;
`ifdef BANK_SC_ARB_AGE_EN
    chk("age_sat_ready", 32'(req_ready), 32'h4);
    cyc();
    chk("age_sat_gid", 32'(gid), 32'h2);
    chk("age_sat_rr", 32'(dut.r_rr_ptr), 32'h0);
`else
    chk("pure_rr_ready", 32'(req_ready), 32'h2);
    cyc();
    chk("pure_rr_gid", 32'(gid), 32'h1);
    chk("pure_rr_ptr", 32'(dut.r_rr_ptr), 32'h2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bank_sc_arbiter.md
BANK_SC_ARBITER -- requirements
Module: bank_sc_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, meaning the number of requesters; only the value 3 is supported. Requester 0 is xbar read/write, 1 is refill linefill, 2 is evict write back.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports req_valid_i, input, 3 bits: per-requester command valid; bit i belongs to requester i.
REQ-005 SHALL have ports req_ready_o, output, 3 bits: per-requester accept.
REQ-006 SHALL have ports req0_cmd_i, req1_cmd_i and req2_cmd_i, input, 23 bits each, packed from MSB to LSB:
  - channel_id, 2 bits
  - opcode, 3 bits
  - set_way_offset, 7 bits
  - wbuffer_id, 8 bits
  - rob_num, 3 bits
REQ-007 SHALL have port isu_sc_valid_o, output, 1 bit: output command valid toward the SRAM controller.
REQ-008 SHALL have port isu_sc_ready_i, input, 1 bit: SRAM controller accepts the output command.
REQ-009 SHALL have output ports isu_sc_channel_id_o (2 bits), isu_sc_opcode_o (3), isu_sc_set_way_offset_o (7), isu_sc_wbuffer_id_o (8) and isu_sc_xbar_rob_num_o (3): the unpacked fields of the registered command.
REQ-010 SHALL have port arb_grant_id_o, output, 2 bits: the requester index of the registered command.

Function
REQ-011 SHALL hold the command in one output register slot, with out_valid driving isu_sc_valid_o.
REQ-012 SHALL define the slot as free when (~out_valid | (isu_sc_valid_o & isu_sc_ready_i)).
REQ-013 SHALL select one winner among the asserted req_valid_i bits each cycle and SHALL assert req_ready_o only for that winner, and only when the slot is free; all other ready bits SHALL be 0.
REQ-014 SHALL load the winner's command and index into the slot in the cycle where valid & ready, so the command appears on isu_sc_valid_o one cycle after acceptance.
REQ-015 SHALL support back-to-back acceptance: a pop and a new load in the same cycle leave out_valid at 1.
REQ-016 SHALL, when the slot is not free, hold all isu_sc_* outputs and arb_grant_id_o stable while isu_sc_valid_o & ~isu_sc_ready_i.
REQ-017 SHALL use a round-robin pointer rr_ptr (2 bits, values 0..2) that sets the search order rr_ptr, rr_ptr+1, rr_ptr+2 modulo 3.
REQ-018 SHALL, after a grant to requester i, update rr_ptr to (i+1) modulo 3; i=2 wraps to 0. rr_ptr SHALL be unchanged in cycles with no grant.
REQ-019 SHALL allow a requester to drop req_valid_i without being granted; the arbiter keeps no memory of withdrawn requests except the age counter behaviour in REQ-025.
REQ-020 SHALL assert no ready bit and leave the slot unchanged when no request is valid.
REQ-021 SHALL treat rr_ptr value 3 as unreachable; if it does occur, the arbiter SHALL treat it as 0.
REQ-022 SHALL NOT inspect the opcode or set_way fields: hazard checking and the write/wbuffer sequencing are owned downstream.

Reset
REQ-023 SHALL, when rst_i is 1 at a clock edge, set the following regardless of other inputs, including mid-handshake:
  - out_valid = 0
  - rr_ptr = 0
  - all age counters = 0
  - arb_grant_id_o = 0
  - isu_sc_* fields = 0
REQ-024 SHALL hold req_ready_o at 0 during any cycle in which rst_i is asserted.

Configuration
REQ-025 SHALL, with macro BANK_SC_ARB_AGE_EN defined, keep one 3-bit saturating age counter per requester:
  - Increment when req_valid_i[i] is 1 and requester i is not granted.
  - Clear on a grant to i, or when req_valid_i[i] is 0.
  - Saturate at 7.
REQ-026 SHALL, with BANK_SC_ARB_AGE_EN defined, give absolute priority to any valid requester whose counter equals 7, with the lowest index winning among several saturated requesters; rr_ptr SHALL still update per REQ-018.
REQ-027 SHALL, without BANK_SC_ARB_AGE_EN, contain no age counters and use pure round-robin arbitration.

Verification
REQ-028 Reset then all three valid, isu_sc_ready_i=1 -> grants 0,1,2,0 on consecutive cycles, and isu_sc_valid_o is 1 from the second cycle onward.
REQ-029 Requester 1 alone with cmd 23'h1A5A5A, isu_sc_ready_i=0 for 4 cycles -> req_ready_o[1]=1 only in the first cycle, outputs hold 23'h1A5A5A fields, and arb_grant_id_o=1 throughout.
REQ-030 rr_ptr=2 with only requesters 0 and 2 valid -> requester 2 is granted, then requester 0, and rr_ptr wraps to 0 then 1.
REQ-031 rst_i pulsed in the cycle where requester 0 valid & ready and out_valid=1 -> next cycle out_valid=0, rr_ptr=0, and the command is not loaded.
REQ-032 With BANK_SC_ARB_AGE_EN: requesters 0 and 1 always valid, requester 2 valid but isu_sc_ready_i pattern gated so that requester 2 loses 7 times -> on the next free slot requester 2 is granted regardless of rr_ptr.
REQ-033 Requester 0 valid for 2 cycles with slot full, then dropped -> no grant, no output change, and rr_ptr unchanged.
